// File: rtl/seven_seg_pkg.sv
// Shared seven-segment code table (segments a..g, index 0 = a, active-low)
// and the forward/inverse conversion helpers.
package seven_seg_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } rd_state_e;

  // {err, nibble}; unknown patterns decode to nibble 0 with err set
  function automatic logic [4:0] seg_to_hex(
    input seg_t s
  );
    logic [4:0] r;
    r = 5'b1_0000;
    unique case (s)
      SEG_0:   r = 5'h00;
      SEG_1:   r = 5'h01;
      SEG_2:   r = 5'h02;
      SEG_3:   r = 5'h03;
      SEG_4:   r = 5'h04;
      SEG_5:   r = 5'h05;
      SEG_6:   r = 5'h06;
      SEG_7:   r = 5'h07;
      SEG_8:   r = 5'h08;
      SEG_9:   r = 5'h09;
      SEG_A:   r = 5'h0A;
      SEG_B:   r = 5'h0B;
      SEG_C:   r = 5'h0C;
      SEG_D:   r = 5'h0D;
      SEG_E:   r = 5'h0E;
      SEG_F:   r = 5'h0F;
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

  function automatic seg_t hex_to_seg(
    input logic [3:0] h
  );
    seg_t r;
    r = SEG_BLANK;
    unique case (h)
      4'h0: r = SEG_0;
      4'h1: r = SEG_1;
      4'h2: r = SEG_2;
      4'h3: r = SEG_3;
      4'h4: r = SEG_4;
      4'h5: r = SEG_5;
      4'h6: r = SEG_6;
      4'h7: r = SEG_7;
      4'h8: r = SEG_8;
      4'h9: r = SEG_9;
      4'hA: r = SEG_A;
      4'hB: r = SEG_B;
      4'hC: r = SEG_C;
      4'hD: r = SEG_D;
      4'hE: r = SEG_E;
      4'hF: r = SEG_F;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_reader_if.sv
// Frame output port of the segment reader: valid/ready plus
// the assembled digit values and per-digit error flags.
interface seven_seg_reader_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_err;

  modport master (
    output out_valid,
    output value,
    output digit_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  value,
    input  digit_err,
    output out_ready
  );

endinterface

// File: rtl/seven_seg_inv_decode.sv
// Combinational inverse decoder: active-low segment pattern to
// hex nibble, flagging patterns that are not a legal hex glyph.
module seven_seg_inv_decode
  import seven_seg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  logic [4:0] dec;

  assign dec      = seg_to_hex(seg_i);
  assign err_o    = dec[4];
  assign nibble_o = dec[3:0];

endmodule

// File: rtl/seven_seg_reader.sv
// Samples a multiplexed 7-segment display bus and reassembles
// one hex nibble per digit into frames on a valid/ready port.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  seg_t                  seg,
  input  logic [NUM_DIGITS-1:0] an,
  seven_seg_reader_if.master    out_if,
  output logic                  overrun
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(STABLE_CYCLES - 1);

  seg_t                  seg_s1_q;
  seg_t                  seg_s2_q;
  seg_t                  seg_p_q;
  logic [NUM_DIGITS-1:0] an_s1_q;
  logic [NUM_DIGITS-1:0] an_s2_q;
  logic [NUM_DIGITS-1:0] an_p_q;

  // Idle the pipeline at "blank, no digit" so release never looks like a digit
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      seg_s1_q <= SEG_BLANK;
      seg_s2_q <= SEG_BLANK;
      seg_p_q  <= SEG_BLANK;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      an_p_q   <= '1;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      an_p_q   <= an_s2_q;
    end
  end

  logic [NUM_DIGITS-1:0] sel;
  logic                  one_hot;
  logic                  changed;

  assign sel     = ~an_s2_q;
  assign one_hot = $onehot(sel);
  assign changed = (seg_s2_q != seg_p_q)
                || (an_s2_q != an_p_q);

  logic [3:0] nib;
  logic       nib_err;

  seven_seg_inv_decode u_dec (
    .seg_i    (seg_s2_q),
    .nibble_o (nib),
    .err_o    (nib_err)
  );

  rd_state_e     state_q;
  rd_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          capture;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (one_hot) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (changed) begin
          cnt_d   = '0;
          state_d = one_hot ? ST_SETTLE : ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (changed) begin
          cnt_d   = '0;
          state_d = one_hot ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  logic [VW-1:0]         stage_q;
  logic [VW-1:0]         stage_d;
  logic [NUM_DIGITS-1:0] serr_q;
  logic [NUM_DIGITS-1:0] serr_d;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [NUM_DIGITS-1:0] mask_d;
  logic [NUM_DIGITS-1:0] mask_set;
  logic                  frame_done;

  always_comb begin
    stage_d  = stage_q;
    serr_d   = serr_q;
    mask_set = mask_q;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel[i]) begin
          stage_d[4*i +: 4] = nib;
          serr_d[i]         = nib_err;
        end
      end
      mask_set = mask_q | sel;
    end
    frame_done = capture && (&mask_set);
    mask_d     = frame_done ? '0 : mask_set;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stage_q <= '0;
      serr_q  <= '0;
      mask_q  <= '0;
    end else begin
      stage_q <= stage_d;
      serr_q  <= serr_d;
      mask_q  <= mask_d;
    end
  end

  logic                  valid_q;
  logic                  valid_d;
  logic [VW-1:0]         value_q;
  logic [VW-1:0]         value_d;
  logic [NUM_DIGITS-1:0] derr_q;
  logic [NUM_DIGITS-1:0] derr_d;
  logic                  ovr_q;
  logic                  ovr_d;

  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    derr_d  = derr_q;
    ovr_d   = ovr_q;
    if (frame_done) begin
      if (!valid_q || out_if.out_ready) begin
        valid_d = 1'b1;
        value_d = stage_d;
        derr_d  = serr_d;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      valid_q <= 1'b0;
      value_q <= '0;
      derr_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      value_q <= value_d;
      derr_q  <= derr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.value     = value_q;
  assign out_if.digit_err = derr_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed and randomized scans of the segment reader against a
// dwell-time reference model of digit capture and frame delivery.
module tb_seven_seg_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  localparam logic [0:6] BLANK = 7'b1111111;
  localparam logic [0:6] CODES [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic [0:6]    seg;
  logic [ND-1:0] an;
  logic          overrun;

  seven_seg_reader_if #(.NUM_DIGITS(ND)) oif ();

  seven_seg_reader #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .seg     (seg),
    .an      (an),
    .out_if  (oif),
    .overrun (overrun)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int fails  = 0;

  logic [19:0] xfer_q [$];
  logic [19:0] exp_q  [$];

  always @(posedge Clock)
    if (Resetn && oif.out_valid && oif.out_ready)
      xfer_q.push_back({oif.digit_err, oif.value});

  // Model state: dwell of the current (an, seg) pair and frame bookkeeping
  logic [3:0]  m_an;
  logic [0:6]  m_seg;
  int          m_run;
  bit          m_capd;
  logic [3:0]  m_mask;
  logic [3:0]  m_val [4];
  logic [3:0]  m_err;
  bit          m_ready;
  bit          m_held;
  logic [19:0] m_held_frame;
  bit          m_ovr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [0:6] s);
    for (int i = 0; i < 16; i++)
      if (s == CODES[i]) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  function automatic int low_index(input logic [3:0] a);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 4; i++)
      if (!a[i]) begin n++; k = i; end
    return (n == 1) ? k : -1;
  endfunction

  task automatic m_reset();
    m_mask = '0;
    m_held = 0;
    m_ovr  = 0;
    m_an   = 4'hF;
    m_seg  = BLANK;
    m_run  = 0;
    m_capd = 1;
    m_err  = '0;
    for (int i = 0; i < 4; i++) m_val[i] = '0;
  endtask

  task automatic model_capture(input int idx, input logic [0:6] s);
    logic [4:0]  d;
    logic [19:0] fr;
    d = ref_decode(s);
    m_val[idx]  = d[3:0];
    m_err[idx]  = d[4];
    m_mask[idx] = 1'b1;
    if (m_mask == 4'hF) begin
      m_mask = '0;
      fr = {m_err, m_val[3], m_val[2], m_val[1], m_val[0]};
      if (m_ready) exp_q.push_back(fr);
      else if (!m_held) begin m_held = 1; m_held_frame = fr; end
      else m_ovr = 1;
    end
  endtask

  // A digit is taken once its pair has been steady for SC+1 input cycles
  task automatic hold(input logic [3:0] a, input logic [0:6] s,
                      input int d);
    int idx;
    an  = a;
    seg = s;
    repeat (d) begin @(posedge Clock); #1; end
    if (a == m_an && s == m_seg) m_run += d;
    else begin m_run = d; m_capd = 0; end
    m_an  = a;
    m_seg = s;
    idx = low_index(a);
    if (!m_capd && idx >= 0 && m_run >= SC + 1) begin
      m_capd = 1;
      model_capture(idx, s);
    end
  endtask

  task automatic expect_last(input string tag, input logic [19:0] e);
    hold(4'hF, BLANK, 12);
    chk({tag, "_seen"}, 32'(xfer_q.size() != 0), 32'd1);
    if (xfer_q.size() != 0)
      chk({tag, "_value"}, 32'(xfer_q[$]), 32'(e));
  endtask

  task automatic settle(input string tag);
    hold(4'hF, BLANK, 12);
    chk({tag, "_count"}, xfer_q.size(), exp_q.size());
    for (int i = 0; i < xfer_q.size() && i < exp_q.size(); i++)
      chk({tag, "_frame"}, 32'(xfer_q[i]), 32'(exp_q[i]));
    xfer_q.delete();
    exp_q.delete();
    chk({tag, "_valid"}, 32'(oif.out_valid), 32'(m_held));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    if (m_held)
      chk({tag, "_heldval"}, 32'({oif.digit_err, oif.value}),
          32'(m_held_frame));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(oif.out_valid), 32'd0);
    chk({tag, "_value"}, 32'(oif.value), 32'd0);
    chk({tag, "_err"}, 32'(oif.digit_err), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  task automatic pulse_reset();
    an  = 4'hF;
    seg = BLANK;
    Resetn = 1'b0;
    repeat (2) begin @(posedge Clock); #1; end
    chk_zero("rst_pulse");
    Resetn = 1'b1;
    m_reset();
  endtask

  initial begin
    m_reset();
    m_ready = 1;
    oif.out_ready = 1'b0;
    an  = 4'hF;
    seg = BLANK;

    for (int i = 0; i < 6; i++) begin
      an  = 4'($urandom);
      seg = 7'($urandom);
      oif.out_ready = 1'($urandom);
      @(posedge Clock); #1;
      if (i >= 1) chk_zero("reset_hold");
    end
    an  = 4'hF;
    seg = BLANK;
    oif.out_ready = 1'b1;
    Resetn = 1'b1;
    m_reset();
    hold(4'hF, BLANK, 5);
    chk_zero("post_reset");

    hold(4'b1110, CODES[4], 8);
    hold(4'b1101, CODES[3], 8);
    hold(4'b1011, CODES[2], 8);
    hold(4'b0111, CODES[1], 8);
    expect_last("scan", {4'h0, 16'h1234});
    settle("scan");

    hold(4'b1110, CODES[4], 3);
    hold(4'b1110, CODES[7], 1);
    hold(4'b1110, CODES[4], 8);
    hold(4'b1101, CODES[3], 8);
    hold(4'b1011, BLANK, 8);
    hold(4'b0111, CODES[1], 8);
    expect_last("blank_glitch", {4'b0100, 16'h1034});
    settle("blank_glitch");

    hold(4'b1101, CODES[9], 5);
    hold(4'b1011, CODES[10], 5);
    hold(4'b0111, CODES[11], 5);
    hold(4'b1110, CODES[12], 4);
    settle("short_dwell");
    hold(4'b1110, CODES[12], 5);
    expect_last("exact_dwell", {4'h0, 16'hBA9C});
    settle("exact_dwell");

    oif.out_ready = 1'b0;
    m_ready = 0;
    for (int f = 0; f < 2; f++)
      for (int dg = 0; dg < 4; dg++)
        hold(~(4'b0001 << dg), CODES[(f == 0) ? 8 - dg : 12 - dg], 7);
    settle("stall");
    chk("stall_value", 32'(oif.value), 32'h5678);
    chk("stall_overrun", 32'(overrun), 32'd1);
    oif.out_ready = 1'b1;
    m_ready = 1;
    exp_q.push_back(m_held_frame);
    m_held = 0;
    @(posedge Clock); #1;
    chk("release_valid", 32'(oif.out_valid), 32'd0);
    settle("release");

    hold(4'b1110, CODES[13], 8);
    hold(4'b1101, CODES[14], 8);
    hold(4'b1100, CODES[8], 20);
    settle("two_low");
    hold(4'b1011, CODES[15], 8);
    hold(4'b0111, CODES[0], 8);
    expect_last("two_low_done", {4'h0, 16'h0FED});
    settle("two_low_done");

    hold(4'b1110, CODES[1], 8);
    hold(4'b1101, CODES[2], 8);
    pulse_reset();
    hold(4'b1011, CODES[3], 8);
    hold(4'b0111, CODES[4], 8);
    settle("reset_mid");
    hold(4'b1110, CODES[5], 8);
    hold(4'b1101, CODES[6], 8);
    settle("reset_refill");

    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 25; s++) begin
        logic [3:0] a;
        logic [0:6] sg;
        if ($urandom_range(9, 0) < 7)
          a = ~(4'b0001 << $urandom_range(3, 0));
        else
          a = 4'($urandom);
        if ($urandom_range(9, 0) < 8)
          sg = CODES[$urandom_range(15, 0)];
        else
          sg = 7'($urandom);
        hold(a, sg, $urandom_range(9, 1));
      end
      settle("random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
